// File: rtl/vending_change_scheduler.sv
// Change-return sequencer: greedy 1000/500/100 coins limited by inventory.
// Optional ejector stall timeout enabled by defining CHANGE_TIMEOUT_EN.
module vending_change_scheduler #(
    parameter int TOTAL_BITS     = 31,
    parameter int INV_BITS       = 8,
    parameter int INV_INIT       = 10,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [TOTAL_BITS-1:0] i_req_amount,
    output logic                  o_req_ready,
    input  logic [2:0]            i_coin_refill,
    output logic [2:0]            o_return_coin,
    input  logic                  i_eject_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_shortfall,
    output logic                  o_timeout,
    output logic [INV_BITS-1:0]   o_inv_100,
    output logic [INV_BITS-1:0]   o_inv_500,
    output logic [INV_BITS-1:0]   o_inv_1000
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE
    } state_t;

    localparam logic [TOTAL_BITS-1:0] VAL_100  = TOTAL_BITS'(100);
    localparam logic [TOTAL_BITS-1:0] VAL_500  = TOTAL_BITS'(500);
    localparam logic [TOTAL_BITS-1:0] VAL_1000 = TOTAL_BITS'(1000);
    localparam logic [INV_BITS-1:0]   INV_RST  = INV_BITS'(INV_INIT);

    state_t                state;
    state_t                next_state;
    logic [TOTAL_BITS-1:0] remaining;
    logic [2:0]            pick;
    logic [TOTAL_BITS-1:0] coin_val;
    logic                  handshake;
    logic                  accept;
    logic                  timeout_hit;
    logic [2:0]            dec;

    assign accept    = (state == S_IDLE) && i_req_valid;
    assign handshake = (state == S_EJECT) && i_eject_ready;
    assign dec       = handshake ? o_return_coin : 3'b000;

    // Largest denomination that fits the remainder and is in stock
    always_comb begin
        pick = 3'b000;
        if (remaining >= VAL_1000 && o_inv_1000 != '0) begin
            pick = 3'b100;
        end else if (remaining >= VAL_500 && o_inv_500 != '0) begin
            pick = 3'b010;
        end else if (remaining >= VAL_100 && o_inv_100 != '0) begin
            pick = 3'b001;
        end
    end

    // Face value of the coin currently offered to the ejector
    always_comb begin
        coin_val = '0;
        unique case (1'b1)
            o_return_coin[2]: coin_val = VAL_1000;
            o_return_coin[1]: coin_val = VAL_500;
            o_return_coin[0]: coin_val = VAL_100;
            default:          coin_val = '0;
        endcase
    end

`ifdef CHANGE_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] stall_cnt;
    logic                timeout_q;

    assign timeout_hit = (state == S_EJECT) && !i_eject_ready &&
                         (stall_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
    assign o_timeout   = timeout_q;

    // Consecutive stalled EJECT cycles; cleared on handshake or exit
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == S_EJECT && !i_eject_ready && !timeout_hit) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    // Timeout flag lives until the next request is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (i_req_valid) next_state = S_SELECT;
            S_SELECT: next_state = (pick != 3'b000) ? S_EJECT : S_DONE;
            S_EJECT: begin
                if (handshake) begin
                    next_state = S_SELECT;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        o_req_ready = (state == S_IDLE);
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_DONE);
    end

    // Remainder, offered coin and shortfall datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining     <= '0;
            o_return_coin <= 3'b000;
            o_shortfall   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        remaining   <= i_req_amount;
                        o_shortfall <= '0;
                    end
                end
                S_SELECT: begin
                    o_return_coin <= pick;
                    if (pick == 3'b000) begin
                        o_shortfall <= remaining;
                    end
                end
                S_EJECT: begin
                    if (handshake) begin
                        remaining     <= remaining - coin_val;
                        o_return_coin <= 3'b000;
                    end else if (timeout_hit) begin
                        o_return_coin <= 3'b000;
                        o_shortfall   <= remaining;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    function automatic logic [INV_BITS-1:0] inv_step(
        input logic [INV_BITS-1:0] cur,
        input logic                inc,
        input logic                dc
    );
        if (inc && !dc) begin
            return (cur == '1) ? cur : cur + 1'b1;
        end else if (dc && !inc) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

    // Inventory: refill strobes add, dispensed coins subtract
    always_ff @(posedge clk) begin
        if (reset) begin
            o_inv_100  <= INV_RST;
            o_inv_500  <= INV_RST;
            o_inv_1000 <= INV_RST;
        end else begin
            o_inv_100  <= inv_step(o_inv_100,  i_coin_refill[0], dec[0]);
            o_inv_500  <= inv_step(o_inv_500,  i_coin_refill[1], dec[1]);
            o_inv_1000 <= inv_step(o_inv_1000, i_coin_refill[2], dec[2]);
        end
    end

endmodule
